// File: rtl/ota_sd_pkg.sv
// Shared definitions for the OTA sigma-delta readout: FSM state encoding,
// default sizing constants and the saturating clip used when publishing a code.
package ota_sd_pkg;

  localparam int OSR_LOG2_DEF      = 8;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int CODE_W_DEF        = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Clamp a count to the largest representable output code.
  function automatic logic [31:0] sat_clip(input logic [31:0] value,
                                           input logic [31:0] max_code);
    return (value > max_code) ? max_code : value;
  endfunction

endpackage

// File: rtl/ota_sd_sync.sv
// Two-flop synchronizer for asynchronous analog-tile signals (e.g. comparator
// outputs on ua). Output is the input delayed by two clk cycles.
module ota_sd_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make meta->q a real two-stage shift;
      // blocking ones would collapse it into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ota_sd_readout.sv
// First-order sigma-delta back end for the OTA/comparator tile. The
// synchronized comparator bit is fed back to the OTA and ones are counted
// over a 2^OSR_LOG2-cycle window; the count is published as an unsigned,
// saturated code with a valid/ack handshake.
// Build option: define OTA_SD_CONT_EN for continuous back-to-back conversion
// (DONE returns straight to SETTLE, overrun reported through sat).
module ota_sd_readout
  import ota_sd_pkg::*;
#(
  parameter int OSR_LOG2      = OSR_LOG2_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CODE_W        = CODE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmp_in,
  input  logic              start,
  input  logic              code_ack,
  output logic              fb_out,
  output logic              busy,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              sat
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] SETTLE  = ST_SETTLE;
  localparam logic [1:0] CONVERT = ST_CONVERT;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]    SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [OSR_LOG2-1:0] WIN_LOAD = {OSR_LOG2{1'b1}};
  localparam logic [31:0]         MAX_CODE = 32'((1 << CODE_W) - 1);

  logic                cmp_s;
  logic [1:0]          state, state_nxt;
  logic [SET_W-1:0]    settle_cnt, settle_nxt;
  logic [OSR_LOG2-1:0] win_cnt, win_nxt;
  logic [OSR_LOG2:0]   ones_cnt, ones_nxt;   // one extra bit: holds 2^OSR_LOG2 without wrapping
  logic                fb_q, fb_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic                sat_nxt, valid_nxt;

  ota_sd_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cmp_in),
    .q     (cmp_s)
  );

  assign busy   = (state == SETTLE) || (state == CONVERT);
  // Feedback only drives the OTA while the loop is closed and the tile is enabled.
  assign fb_out = fb_q & ena & busy;

  // Next-state logic for the conversion FSM, counters and result registers.
  always_comb begin
    // NOTE: every signal gets a hold-value default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt  = state;
    settle_nxt = settle_cnt;
    win_nxt    = win_cnt;
    ones_nxt   = ones_cnt;
    fb_nxt     = fb_q;
    code_nxt   = code;
    sat_nxt    = sat;
    valid_nxt  = code_valid;

    // Acknowledge consumes the result; harmless when nothing is pending.
    if (code_ack) valid_nxt = 1'b0;

    // With ena low everything above simply holds: the loop resumes in place.
    if (ena) begin
      fb_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt  = SETTLE;
            settle_nxt = SET_LOAD;
            ones_nxt   = '0;
          end
        end
        SETTLE: begin
          fb_nxt = cmp_s;
          if (settle_cnt == '0) begin
            state_nxt = CONVERT;
            win_nxt   = WIN_LOAD;
          end else begin
            settle_nxt = settle_cnt - SET_W'(1);
          end
        end
        CONVERT: begin
          fb_nxt   = cmp_s;
          ones_nxt = ones_cnt + (OSR_LOG2 + 1)'(cmp_s);
          if (win_cnt == '0) state_nxt = DONE;
          else               win_nxt   = win_cnt - OSR_LOG2'(1);
        end
        DONE: begin
          // A fresh result always overrides a same-cycle acknowledge.
          code_nxt  = CODE_W'(sat_clip(32'(ones_cnt), MAX_CODE));
          sat_nxt   = (32'(ones_cnt) > MAX_CODE);
          valid_nxt = 1'b1;
`ifdef OTA_SD_CONT_EN
          // An unacknowledged previous result means the consumer fell behind.
          if (code_valid && !code_ack) sat_nxt = 1'b1;
          state_nxt  = SETTLE;
          settle_nxt = SET_LOAD;
          ones_nxt   = '0;
`else
          state_nxt  = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      ones_cnt   <= '0;
      fb_q       <= 1'b0;
      code       <= '0;
      sat        <= 1'b0;
      code_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      win_cnt    <= win_nxt;
      ones_cnt   <= ones_nxt;
      fb_q       <= fb_nxt;
      code       <= code_nxt;
      sat        <= sat_nxt;
      code_valid <= valid_nxt;
    end
  end

endmodule
